// File: rtl/fifo_sync_param_if.sv
// Bundle of the FIFO's request, data and status signals.
// The producer/consumer side uses the master modport; the FIFO uses slave.
interface fifo_sync_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  wr;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rd;
    logic                  err_clr;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [CW-1:0]         fifo_count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr, data_in, rd, err_clr,
        input  data_out, empty, full, almost_empty, almost_full,
               fifo_count, overflow, underflow
    );

    modport slave (
        input  wr, data_in, rd, err_clr,
        output data_out, empty, full, almost_empty, almost_full,
               fifo_count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with registered read data, occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module fifo_sync_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_MARGIN  = 1,
    parameter int AE_MARGIN  = 1
) (
    input  logic             clk,
    input  logic             rst,
    fifo_sync_param_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Threshold levels are folded into constants so the flag decodes are
    // a single compare each. A margin of DEPTH or more pins almost_full high.
    localparam bit            AF_ALWAYS = (AF_MARGIN >= DEPTH);
    localparam logic [CW-1:0] DEPTH_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL    = AF_ALWAYS ? '0 : CW'(DEPTH - AF_MARGIN);
    localparam logic [CW-1:0] AE_LVL    = CW'(AE_MARGIN);

    // Storage is deliberately not reset; pointers make stale words unreachable.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]         wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0]         count_q,    count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  ovf_q,      ovf_d;
    logic                  udf_q,      udf_d;

    logic empty_w;
    logic full_w;
    logic wa;
    logic ra;

    // Status flags decode the registered count, so they move with fifo_count.
    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == DEPTH_LVL);

    // A write at full is still accepted when a read frees a slot the same
    // cycle; a read at empty is never accepted, even with a concurrent write.
    assign wa = bus.wr & (~full_w | bus.rd);
    assign ra = bus.rd & ~empty_w;

    assign bus.empty        = empty_w;
    assign bus.full         = full_w;
    assign bus.almost_empty = (count_q <= AE_LVL);
    assign bus.almost_full  = AF_ALWAYS | (count_q >= AF_LVL);
    assign bus.fifo_count   = count_q;
    assign bus.data_out     = data_out_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

    // Next-state for pointers, count, read data and sticky error flags.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        ovf_d      = ovf_q;
        udf_d      = udf_q;

        if (wa) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (ra) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            data_out_d = mem[rd_ptr_q];
        end

        case ({wa, ra})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A new error event on the same edge as err_clr leaves the flag set.
        if (err_clr_evt(bus.err_clr)) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (bus.wr & full_w & ~bus.rd) begin
            ovf_d = 1'b1;
        end
        if (bus.rd & empty_w) begin
            udf_d = 1'b1;
        end
    end

    function automatic logic err_clr_evt(input logic clr);
        return clr;
    endfunction

    // Control and read-data registers; reset takes effect without a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    // Write port of the storage array.
    always_ff @(posedge clk) begin
        if (wa) begin
            mem[wr_ptr_q] <= bus.data_in;
        end
    end
endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: default configuration plus a
// 16-deep, 32-bit instance with wider margins.
module tb_fifo_sync_param;
    logic clk;
    logic rst;

    int n_cmp;
    int n_mis;

    fifo_sync_param_if #(.DATA_WIDTH(8),  .DEPTH(8))  b0 ();
    fifo_sync_param_if #(.DATA_WIDTH(32), .DEPTH(16)) b1 ();

    fifo_sync_param #(
        .DATA_WIDTH(8), .DEPTH(8), .AF_MARGIN(1), .AE_MARGIN(1)
    ) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    fifo_sync_param #(
        .DATA_WIDTH(32), .DEPTH(16), .AF_MARGIN(4), .AE_MARGIN(2)
    ) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle0();
        b0.wr = 1'b0; b0.rd = 1'b0; b0.err_clr = 1'b0; b0.data_in = '0;
    endtask

    task automatic idle1();
        b1.wr = 1'b0; b1.rd = 1'b0; b1.err_clr = 1'b0; b1.data_in = '0;
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        idle0();
        idle1();
        rst = 1'b0;

        // Reset state
        #12;
        chk("rst_count",  b0.fifo_count,   0);
        chk("rst_empty",  b0.empty,        1);
        chk("rst_full",   b0.full,         0);
        chk("rst_ae",     b0.almost_empty, 1);
        chk("rst_af",     b0.almost_full,  0);
        chk("rst_dout",   b0.data_out,     0);
        chk("rst_ovf",    b0.overflow,     0);
        chk("rst_udf",    b0.underflow,    0);
        chk("rst1_af",    b1.almost_full,  0);
        rst = 1'b1;
        tick();

        // Fill 0x10..0x17
        for (int i = 0; i < 8; i++) begin
            b0.wr = 1'b1; b0.data_in = 8'(8'h10 + i);
            tick();
            chk("fill_count", b0.fifo_count,   i + 1);
            chk("fill_af",    b0.almost_full,  (i + 1) >= 7);
            chk("fill_full",  b0.full,         (i + 1) == 8);
            chk("fill_ae",    b0.almost_empty, (i + 1) <= 1);
            chk("fill_empty", b0.empty,        0);
        end

        // Overflow at full, then clear
        b0.wr = 1'b1; b0.data_in = 8'hAA; b0.rd = 1'b0;
        tick();
        idle0();
        chk("ovf_count", b0.fifo_count, 8);
        chk("ovf_flag",  b0.overflow,   1);
        chk("ovf_full",  b0.full,       1);
        tick();
        chk("ovf_sticky", b0.overflow, 1);
        b0.err_clr = 1'b1;
        tick();
        idle0();
        chk("ovf_clr", b0.overflow, 0);

        // Drain; 0xAA must never appear
        for (int i = 0; i < 8; i++) begin
            b0.rd = 1'b1;
            tick();
            chk("drain_data",  b0.data_out,   8'h10 + i);
            chk("drain_count", b0.fifo_count, 7 - i);
        end
        idle0();
        chk("drain_empty", b0.empty, 1);
        tick();
        chk("dout_hold", b0.data_out, 8'h17);

        // Read+write while empty: only the write is taken
        b0.rd = 1'b1; b0.wr = 1'b1; b0.data_in = 8'h55;
        tick();
        idle0();
        chk("udf_count", b0.fifo_count, 1);
        chk("udf_flag",  b0.underflow,  1);
        chk("udf_dout",  b0.data_out,   8'h17);
        b0.rd = 1'b1;
        tick();
        idle0();
        chk("udf_read",   b0.data_out,   8'h55);
        chk("udf_cnt0",   b0.fifo_count, 0);
        b0.err_clr = 1'b1;
        tick();
        idle0();
        chk("udf_clr", b0.underflow, 0);
        // New underflow on the same edge as err_clr: flag ends set
        b0.rd = 1'b1; b0.err_clr = 1'b1;
        tick();
        idle0();
        chk("udf_setwins", b0.underflow, 1);
        b0.err_clr = 1'b1;
        tick();
        idle0();
        chk("udf_clr2", b0.underflow, 0);

        // Read+write at full
        for (int i = 0; i < 8; i++) begin
            b0.wr = 1'b1; b0.data_in = 8'(i);
            tick();
        end
        idle0();
        chk("rw_full_pre", b0.full, 1);
        b0.rd = 1'b1; b0.wr = 1'b1; b0.data_in = 8'h99;
        tick();
        idle0();
        chk("rw_dout",  b0.data_out,   0);
        chk("rw_count", b0.fifo_count, 8);
        chk("rw_ovf",   b0.overflow,   0);
        for (int i = 0; i < 8; i++) begin
            b0.rd = 1'b1;
            tick();
            chk("rw_drain", b0.data_out, (i < 7) ? (i + 1) : 8'h99);
        end
        idle0();
        chk("rw_empty", b0.empty, 1);

        // Asynchronous reset between edges with 5 words stored
        for (int i = 0; i < 5; i++) begin
            b0.wr = 1'b1; b0.data_in = 8'(8'h61 + i);
            tick();
        end
        idle0();
        chk("ar_count5", b0.fifo_count, 5);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_count", b0.fifo_count, 0);
        chk("ar_empty", b0.empty,      1);
        chk("ar_dout",  b0.data_out,   0);
        tick();
        rst = 1'b1;
        b0.wr = 1'b1; b0.data_in = 8'h3C;
        tick();
        idle0();
        chk("ar_wcount", b0.fifo_count, 1);
        b0.rd = 1'b1;
        tick();
        idle0();
        chk("ar_read",  b0.data_out,   8'h3C);
        chk("ar_cnt0",  b0.fifo_count, 0);

        // 16-deep, 32-bit instance: fill and drain
        for (int i = 0; i < 16; i++) begin
            b1.wr = 1'b1; b1.data_in = 32'hA000_0000 + 32'(i);
            tick();
            chk("w_count", b1.fifo_count,   i + 1);
            chk("w_af",    b1.almost_full,  (i + 1) >= 12);
            chk("w_ae",    b1.almost_empty, (i + 1) <= 2);
            chk("w_full",  b1.full,         (i + 1) == 16);
        end
        idle1();
        for (int i = 0; i < 16; i++) begin
            b1.rd = 1'b1;
            tick();
            chk("w_data", b1.data_out,     32'hA000_0000 + 32'(i));
            chk("w_dcnt", b1.fifo_count,   15 - i);
            chk("w_dae",  b1.almost_empty, (15 - i) <= 2);
            chk("w_daf",  b1.almost_full,  (15 - i) >= 12);
        end
        idle1();
        chk("w_empty", b1.empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
